// File: rtl/add_sub_acc.sv
// Registered add/sub/accumulate unit with valid/ready handshake on both sides.
// Overflow follows unsigned or two's-complement rules; optional saturation.
module add_sub_acc #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0,
  parameter bit SAT    = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       op_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_LD  = 2'b11;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] opa, opb, raw, res;
  logic [WIDTH:0]   sum, diff;
  logic             is_sub, carry_c, ovf_c, sovf, in_fire;

  assign in_ready_o = !valid_q || out_ready_i;
  assign in_fire    = in_valid_i && in_ready_o;

  always_comb begin
    opa     = (op_i == OP_ACC) ? acc_q : a_i;
    opb     = (op_i == OP_ACC) ? a_i : b_i;
    is_sub  = (op_i == OP_SUB);
    sum     = {1'b0, opa} + {1'b0, opb};
    diff    = {1'b0, opa} - {1'b0, opb};
    raw     = is_sub ? diff[WIDTH-1:0] : sum[WIDTH-1:0];
    // bit WIDTH of the extended difference is the borrow (a < b)
    carry_c = is_sub ? diff[WIDTH] : sum[WIDTH];
    if (is_sub) begin
      sovf = (opa[WIDTH-1] != opb[WIDTH-1]) && (raw[WIDTH-1] != opa[WIDTH-1]);
    end else begin
      sovf = (opa[WIDTH-1] == opb[WIDTH-1]) && (raw[WIDTH-1] != opa[WIDTH-1]);
    end
    ovf_c = SIGNED ? sovf : carry_c;
    res   = raw;
    if (SAT && ovf_c) begin
      if (SIGNED) begin
        // a non-negative first operand can only overflow upwards
        res = opa[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        res = is_sub ? '0 : '1;
      end
    end
    if (op_i == OP_LD) begin
      res     = a_i;
      carry_c = 1'b0;
      ovf_c   = 1'b0;
    end
  end

  always_comb begin
    out_d   = out_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    if (in_fire) begin
      out_d   = res;
      carry_d = carry_c;
      ovf_d   = ovf_c;
      valid_d = 1'b1;
      if (op_i == OP_ACC || op_i == OP_LD) begin
        acc_d = res;
      end
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign out_o       = out_q;
  assign carry_o     = carry_q;
  assign ovf_o       = ovf_q;
  assign out_valid_o = valid_q;

  logic unused_add;
  assign unused_add = (OP_ADD == 2'b00);

endmodule

// File: tb/tb_add_sub_acc.sv
// Bench for add_sub_acc: three instances (unsigned wrap, unsigned sat, signed sat)
// share stimulus; an arithmetic model is compared every cycle plus literal checks.
module tb_add_sub_acc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a_s, b_s;
  logic [1:0] op_s;
  logic       in_valid, out_ready;

  logic [7:0] out_w[3];
  logic       carry_w[3], ovf_w[3], valid_w[3], ready_w[3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  add_sub_acc #(.WIDTH(8), .SIGNED(1'b0), .SAT(1'b0)) u_uw (
    .clk_i(clk), .rst_n_i(rst_n), .a_i(a_s), .b_i(b_s), .op_i(op_s),
    .in_valid_i(in_valid), .in_ready_o(ready_w[0]), .out_o(out_w[0]),
    .carry_o(carry_w[0]), .ovf_o(ovf_w[0]), .out_valid_o(valid_w[0]),
    .out_ready_i(out_ready));

  add_sub_acc #(.WIDTH(8), .SIGNED(1'b0), .SAT(1'b1)) u_us (
    .clk_i(clk), .rst_n_i(rst_n), .a_i(a_s), .b_i(b_s), .op_i(op_s),
    .in_valid_i(in_valid), .in_ready_o(ready_w[1]), .out_o(out_w[1]),
    .carry_o(carry_w[1]), .ovf_o(ovf_w[1]), .out_valid_o(valid_w[1]),
    .out_ready_i(out_ready));

  add_sub_acc #(.WIDTH(8), .SIGNED(1'b1), .SAT(1'b1)) u_ss (
    .clk_i(clk), .rst_n_i(rst_n), .a_i(a_s), .b_i(b_s), .op_i(op_s),
    .in_valid_i(in_valid), .in_ready_o(ready_w[2]), .out_o(out_w[2]),
    .carry_o(carry_w[2]), .ovf_o(ovf_w[2]), .out_valid_o(valid_w[2]),
    .out_ready_i(out_ready));

  task automatic chk(input string nm, input int k, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0d expected %0d", nm, k, act, exp);
    end
  endtask

  // Result from true integer arithmetic: overflow means the mathematical
  // result does not fit the unsigned or signed 8-bit range.
  function automatic void model(input bit sgn, input bit sat, input logic [1:0] op,
                                input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] acc, output logic [7:0] o,
                                output logic c, output logic v);
    int x, y, r, sx, sy, sr;
    if (op == 2'd3) begin
      o = a; c = 1'b0; v = 1'b0;
      return;
    end
    x  = (op == 2'd2) ? int'(acc) : int'(a);
    y  = (op == 2'd2) ? int'(a) : int'(b);
    sx = (x > 127) ? x - 256 : x;
    sy = (y > 127) ? y - 256 : y;
    if (op == 2'd1) begin
      r = x - y;  sr = sx - sy;  c = (x < y);
    end else begin
      r = x + y;  sr = sx + sy;  c = (r > 255);
    end
    v = sgn ? (sr > 127 || sr < -128) : c;
    o = 8'(r & 255);
    if (sat && v) begin
      if (sgn) o = (sr > 127) ? 8'h7f : 8'h80;
      else     o = (op == 2'd1) ? 8'h00 : 8'hff;
    end
  endfunction

  logic [7:0] exp_out[3], exp_acc[3];
  logic       exp_c[3], exp_v[3], exp_valid[3];

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] mo;
    logic       mc, mv;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        exp_out[k] = 8'd0; exp_acc[k] = 8'd0;
        exp_c[k] = 1'b0; exp_v[k] = 1'b0; exp_valid[k] = 1'b0;
      end else if (in_valid && (!exp_valid[k] || out_ready)) begin
        model(k == 2, k >= 1, op_s, a_s, b_s, exp_acc[k], mo, mc, mv);
        exp_out[k] = mo; exp_c[k] = mc; exp_v[k] = mv; exp_valid[k] = 1'b1;
        if (op_s[1]) exp_acc[k] = mo;
      end else if (out_ready) begin
        exp_valid[k] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        chk("rst_valid", k, valid_w[k], 0);
        chk("rst_out", k, out_w[k], 0);
        chk("rst_flags", k, {carry_w[k], ovf_w[k]}, 0);
        chk("rst_ready", k, ready_w[k], 1);
      end else begin
        chk("valid", k, valid_w[k], exp_valid[k]);
        chk("ready", k, ready_w[k], !exp_valid[k] || out_ready);
        if (exp_valid[k]) begin
          chk("out", k, out_w[k], exp_out[k]);
          chk("carry", k, carry_w[k], exp_c[k]);
          chk("ovf", k, ovf_w[k], exp_v[k]);
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    @(posedge clk); #2;
    out_ready = 1'b1; in_valid = 1'b1; op_s = op; a_s = a; b_s = b;
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic lit(input string nm, input int k, input int o, input int c, input int v);
    chk({nm, "_valid"}, k, valid_w[k], 1);
    chk({nm, "_out"}, k, out_w[k], o);
    chk({nm, "_carry"}, k, carry_w[k], c);
    chk({nm, "_ovf"}, k, ovf_w[k], v);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_s = 2'd0; a_s = 8'd0; b_s = 8'd0;
    #1;
    chk("init_out", 0, out_w[0], 0);
    chk("init_valid", 0, valid_w[0], 0);
    chk("init_ready", 0, ready_w[0], 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("ready_after_rst", 0, ready_w[0], 1);

    send(2'd0, 8'd200, 8'd100); @(negedge clk);
    lit("add200", 0, 44, 1, 1); lit("add200", 1, 255, 1, 1); lit("add200", 2, 44, 1, 0);
    send(2'd1, 8'd5, 8'd10); @(negedge clk);
    lit("sub5", 0, 251, 1, 1); lit("sub5", 1, 0, 1, 1); lit("sub5", 2, 251, 1, 0);
    send(2'd0, 8'd100, 8'd100); @(negedge clk);
    lit("add100", 0, 200, 0, 0); lit("add100", 2, 127, 0, 1);
    send(2'd1, 8'd156, 8'd100); @(negedge clk);
    lit("subneg", 0, 56, 0, 0); lit("subneg", 2, 128, 0, 1);

    send(2'd3, 8'd10, 8'd99); @(negedge clk); lit("ld10", 0, 10, 0, 0);
    send(2'd2, 8'd20, 8'd99); @(negedge clk); lit("acc20", 0, 30, 0, 0);
    send(2'd2, 8'd30, 8'd99); @(negedge clk); lit("acc30", 2, 60, 0, 0);

    // backpressure: first input taken, second held off for three cycles
    @(posedge clk); #2;
    out_ready = 1'b0; in_valid = 1'b1; op_s = 2'd0; a_s = 8'd1; b_s = 8'd2;
    @(posedge clk); #2;
    a_s = 8'd3; b_s = 8'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", 0, ready_w[0], 0);
      chk("bp_out", 0, out_w[0], 3);
      chk("bp_valid", 0, valid_w[0], 1);
    end
    @(posedge clk); #2 out_ready = 1'b1;
    @(posedge clk); #2 in_valid = 1'b0;
    @(negedge clk); lit("bp_next", 0, 7, 0, 0);
    @(negedge clk); chk("bp_drain", 0, valid_w[0], 0);

    // reset mid-operation discards a pending output and clears ACC
    @(posedge clk); #2;
    out_ready = 1'b0; in_valid = 1'b1; op_s = 2'd2; a_s = 8'd50;
    @(posedge clk); #2 in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out", 0, out_w[0], 0);
    chk("midrst_valid", 0, valid_w[0], 0);
    chk("midrst_ready", 0, ready_w[0], 1);
    @(posedge clk); #2 rst_n = 1'b1;
    #1 chk("rel_ready", 0, ready_w[0], 1);
    send(2'd2, 8'd5, 8'd0); @(negedge clk);
    lit("acc5", 0, 5, 0, 0); lit("acc5", 1, 5, 0, 0); lit("acc5", 2, 5, 0, 0);

    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #2;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op_s = 2'($urandom_range(0, 3));
      a_s  = 8'($urandom_range(0, 255));
      b_s  = 8'($urandom_range(0, 255));
    end
    @(posedge clk); #2 in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
